// File: rtl/riscv_hazard_ctrl.sv
// rtl/riscv_hazard_ctrl.sv - pipeline stall/flush controller (load-use, MDU, branch, trap)
// Optional per-cause cycle counters: define RISCV_HAZARD_STATS_EN.
module riscv_hazard_ctrl #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int MDU_LAT       = 4,
    parameter int CNT_WIDTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RF_ADDR_WIDTH-1:0] rs1_if2id_ff,
    input  logic [RF_ADDR_WIDTH-1:0] rs2_if2id_ff,
    input  logic                     rs1_used_id,
    input  logic                     rs2_used_id,
    input  logic [RF_ADDR_WIDTH-1:0] rd_id2ex_ff,
    input  logic                     mem_read_id2ex_ff,
    input  logic                     mdu_req_ex,
    input  logic                     branch_taken_ex,
    input  logic                     trap_flush,
    output logic                     pc_stall,
    output logic                     if2id_stall,
    output logic                     if2id_flush,
    output logic                     id2ex_stall,
    output logic                     id2ex_flush,
    output logic                     ex2mem_flush,
    output logic                     mdu_busy,
`ifdef RISCV_HAZARD_STATS_EN
    output logic [31:0]              load_use_cnt,
    output logic [31:0]              mdu_stall_cnt,
    output logic [31:0]              flush_cnt,
`endif
    output logic                     mdu_done
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic                 MULTI    = (MDU_LAT > 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 last_cycle;
    logic                 mdu_stall;
    logic                 done_raw;
    logic                 load_use;
    logic                 lu_stall;
    logic [5:0]           ctl;

    assign last_cycle = (state_q == BUSY) && (cnt_q == '0);
    assign mdu_stall  = MULTI && mdu_req_ex && !trap_flush && !last_cycle;
    assign done_raw   = MULTI ? (last_cycle && !trap_flush) : (mdu_req_ex && !trap_flush);

    assign load_use = mem_read_id2ex_ff && (rd_id2ex_ff != '0) &&
                      ((rs1_used_id && (rs1_if2id_ff == rd_id2ex_ff)) ||
                       (rs2_used_id && (rs2_if2id_ff == rd_id2ex_ff)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (trap_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (mdu_req_ex && MULTI) begin
                state_d = BUSY;
                cnt_d   = CNT_LOAD;
            end
        end else if (cnt_q == '0) begin
            state_d = IDLE;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // ctl = {pc_stall, if2id_stall, if2id_flush, id2ex_stall, id2ex_flush, ex2mem_flush}
    always_comb begin
        ctl      = 6'b000000;
        lu_stall = 1'b0;
        if (trap_flush) begin
            ctl = 6'b001011;
        end else if (mdu_stall) begin
            ctl = 6'b110101;
        end else if (branch_taken_ex) begin
            ctl = 6'b001010;
        end else if (load_use) begin
            ctl      = 6'b110010;
            lu_stall = 1'b1;
        end
    end

    assign pc_stall     = !rst && ctl[5];
    assign if2id_stall  = !rst && ctl[4];
    assign if2id_flush  = !rst && ctl[3];
    assign id2ex_stall  = !rst && ctl[2];
    assign id2ex_flush  = !rst && ctl[1];
    assign ex2mem_flush = !rst && ctl[0];
    assign mdu_busy     = !rst && mdu_stall;
    assign mdu_done     = !rst && done_raw;

`ifdef RISCV_HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            load_use_cnt  <= '0;
            mdu_stall_cnt <= '0;
            flush_cnt     <= '0;
        end else begin
            if (lu_stall)
                load_use_cnt <= load_use_cnt + 32'd1;
            if (mdu_stall)
                mdu_stall_cnt <= mdu_stall_cnt + 32'd1;
            if (ctl[3] || ctl[1] || ctl[0])
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/riscv_hazard_ctrl.md
Name: riscv_hazard_ctrl

Overview:
Pipeline hazard/stall controller for the 5-stage RISC-V core. It covers the hazards that operand bypassing cannot resolve:
- load-use dependencies
- multicycle MDU (mul/div) occupancy of EX
- taken-branch redirects
- trap flushes

It drives stall (hold) and flush (bubble) controls for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
RF_ADDR_WIDTH, 5, register-file address width.
MDU_LAT, 4, total cycles an MDU op occupies EX (>=1); result valid in its last cycle.
CNT_WIDTH, 4, MDU down-counter width; must hold MDU_LAT-1.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
rs1_if2id_ff  in  RF_ADDR_WIDTH  rs1 of instruction in ID.
rs2_if2id_ff  in  RF_ADDR_WIDTH  rs2 of instruction in ID.
rs1_used_id  in  1  ID instruction reads rs1.
rs2_used_id  in  1  ID instruction reads rs2.
rd_id2ex_ff  in  RF_ADDR_WIDTH  rd of instruction in EX.
mem_read_id2ex_ff  in  1  EX instruction is a load.
mdu_req_ex  in  1  EX instruction is a valid MDU op.
branch_taken_ex  in  1  EX resolved taken branch/jump (redirect).
trap_flush  in  1  exception/interrupt redirect from MEM/WB.
pc_stall  out  1  hold PC.
if2id_stall  out  1  hold IF/ID register.
if2id_flush  out  1  load bubble into IF/ID.
id2ex_stall  out  1  hold ID/EX register.
id2ex_flush  out  1  load bubble into ID/EX.
ex2mem_flush  out  1  load bubble into EX/MEM.
mdu_busy  out  1  MDU multicycle in progress (stall active).
mdu_done  out  1  one-cycle pulse: MDU result valid this cycle, pipeline advances.

Behaviour:
- Reset (rst=1 at edge): state IDLE, counter 0. While rst=1, all outputs are forced to 0.
- FSM states:
  - IDLE → BUSY when mdu_req_ex=1, !trap_flush, MDU_LAT>1; counter loaded with MDU_LAT-2.
  - In BUSY, counter decrements each cycle.
  - BUSY with counter==0 → IDLE. That cycle: mdu_done=1, no MDU stall.
  - Any state with trap_flush=1 → IDLE, counter 0. mdu_done is not pulsed.
- MDU stall, combinational: mdu_stall = mdu_req_ex && !trap_flush && !(state==BUSY && counter==0) && MDU_LAT>1.
  - mdu_busy = mdu_stall.
  - Result: exactly MDU_LAT-1 stall cycles per op.
  - MDU_LAT==1: never stalls; mdu_done = mdu_req_ex && !trap_flush.
- Load-use hazard, combinational: load_use = mem_read_id2ex_ff && rd_id2ex_ff!=0 && ((rs1_used_id && rs1_if2id_ff==rd_id2ex_ff) || (rs2_used_id && rs2_if2id_ff==rd_id2ex_ff)).
- Priority, highest first:
  1. trap_flush: if2id_flush=id2ex_flush=ex2mem_flush=1; all stalls 0.
  2. mdu_stall: pc_stall=if2id_stall=id2ex_stall=1, ex2mem_flush=1. Branch and load-use are ignored.
  3. branch_taken_ex: if2id_flush=id2ex_flush=1, no stalls. Overrides load_use.
  4. load_use: pc_stall=if2id_stall=1, id2ex_flush=1. Lasts exactly one cycle, since the load then advances to MEM.
  5. Otherwise all 0.
- Stall and flush of the same register are never both 1.
- Back-to-back MDU ops: a new mdu_req_ex in the cycle after mdu_done starts a fresh sequence from IDLE.
- rst mid-BUSY: the op is abandoned; the pipeline is reset externally.

Optional Feature:
Macro RISCV_HAZARD_STATS_EN.
- Defined: adds outputs load_use_cnt, mdu_stall_cnt, flush_cnt (each 32 bit). They count cycles with load_use stall asserted, mdu_stall asserted, and any flush asserted respectively. Cleared by rst; wrap at 2^32.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Load-use: mem_read_id2ex_ff=1, rd_id2ex_ff=5, rs1_if2id_ff=5, rs1_used_id=1 → pc_stall=if2id_stall=id2ex_flush=1 for 1 cycle. Same stimulus with rd_id2ex_ff=0 or rs1_used_id=0 → all 0.
- MDU_LAT=4: mdu_req_ex held from cycle T → mdu_busy, pc_stall, ex2mem_flush =1 at T..T+2; mdu_done=1 and stalls 0 at T+3.
- Back-to-back MDU ops (MDU_LAT=4): second req at T+4 → stall T+4..T+6, done at T+7. Separate run with MDU_LAT=1 → no stall, done each req cycle.
- Trap during BUSY: trap_flush at T+1 → all three flushes =1, stalls 0. State IDLE at T+2; no mdu_done. A req at T+2 restarts the full 3-cycle stall.
- branch_taken_ex=1 with a simultaneous load_use condition → if2id_flush=id2ex_flush=1, pc_stall=0.
- rst=1 at T+1 of an MDU stall → outputs 0 during reset. After release, state IDLE and a new req gives a full MDU_LAT-1 stall.
